// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared constants for the image burst FIFO slice: default data word width
// and default address width (log2 of the FIFO depth).
// No ports; imported by image_fifo_ram and image_burst_fifo.
// ---------------------------------------------------------------------------
package image_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ADDR_BITS_DEF = 10;

  // Depth of a FIFO with the given address width.
  function automatic int depth_of(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/image_fifo_ram.sv
// ---------------------------------------------------------------------------
// image_fifo_ram
// Simple dual-port RAM, DEPTH x WIDTH, one write port and one read port with
// a registered (1-cycle) read. The read register only updates when re is
// high, so the output holds between reads. Only the read register is reset;
// the storage array is never cleared.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (clears rdata only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable (loads rdata from raddr)
//   raddr  : read address
//   rdata  : registered read data
// ---------------------------------------------------------------------------
module image_fifo_ram
  import image_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = depth_of(ADDR_BITS);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/image_burst_fifo.sv
// ---------------------------------------------------------------------------
// image_burst_fifo
// Synchronous FIFO for image pixel bursts. Besides the usual full/empty
// flags it provides two registered burst-level handshakes:
//   M_Valid : at least M_Count words are stored (downstream may burst-read)
//   S_Ready : room remains for S_Count more words (upstream may burst-write),
//             computed as data_count + S_Count < DEPTH.
// Both flags are evaluated on the current data_count and therefore lag it
// by one cycle.
//
// Optional feature: define IMAGE_FIFO_ERR_FLAGS_EN to build the sticky
// overflow/underflow flags. Without it both flags are tied low and clr_err
// is ignored.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : write data
//   wr_en      : write request (dropped while full)
//   rd_en      : read request (ignored while empty)
//   M_Count    : burst size the downstream wants available
//   S_Count    : burst size the upstream wants to write
//   dout       : read data, valid 1 cycle after an accepted read, holds
//   data_count : stored words, 0..DEPTH
//   full       : data_count == DEPTH
//   empty      : data_count == 0
//   M_Valid    : registered, data_count >= M_Count
//   S_Ready    : registered, data_count + S_Count < DEPTH
//   overflow   : sticky, set by a dropped write
//   underflow  : sticky, set by an ignored read
//   clr_err    : clears overflow/underflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module image_burst_fifo
  import image_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_BITS:0]   M_Count,
  input  logic [ADDR_BITS:0]   S_Count,
  output logic [WIDTH-1:0]     dout,
  output logic [ADDR_BITS:0]   data_count,
  output logic                 full,
  output logic                 empty,
  output logic                 M_Valid,
  output logic                 S_Ready,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int CW    = ADDR_BITS + 1;
  localparam int SW    = ADDR_BITS + 2;
  localparam int DEPTH = depth_of(ADDR_BITS);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [SW-1:0]        room_sum;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign data_count = count;

  // Requests are masked during reset so nothing moves in the reset cycle.
  assign wr_acc = wr_en & ~full  & ~rst;
  assign rd_acc = rd_en & ~empty & ~rst;

  // One extra bit so count + S_Count cannot wrap.
  assign room_sum = {1'b0, count} + {1'b0, S_Count};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      M_Valid <= 1'b0;
      S_Ready <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      M_Valid <= (count >= M_Count);
      S_Ready <= (room_sum < DEPTH_S);
    end
  end

  image_fifo_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

`ifdef IMAGE_FIFO_ERR_FLAGS_EN
  logic drop_wr;
  logic ign_rd;

  assign drop_wr = wr_en & full  & ~rst;
  assign ign_rd  = rd_en & empty & ~rst;

  // Set has priority over clear so an error coinciding with clr_err is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop_wr) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (ign_rd) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_image_burst_fifo.sv
// ---------------------------------------------------------------------------
// tb_image_burst_fifo
// Directed bench for image_burst_fifo with WIDTH=8, ADDR_BITS=4 (DEPTH=16):
// fill/overflow, drain/underflow, M_Valid and S_Ready thresholds,
// simultaneous read/write at full and empty, and a wrapping stream with a
// mid-stream reset. Error-flag expectations follow IMAGE_FIFO_ERR_FLAGS_EN.
// ---------------------------------------------------------------------------
module tb_image_burst_fifo;

  localparam int W  = 8;
  localparam int AB = 4;
  localparam int D  = 16;

`ifdef IMAGE_FIFO_ERR_FLAGS_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic          wr_en;
  logic          rd_en;
  logic [AB:0]   M_Count;
  logic [AB:0]   S_Count;
  logic [W-1:0]  dout;
  logic [AB:0]   data_count;
  logic          full;
  logic          empty;
  logic          M_Valid;
  logic          S_Ready;
  logic          overflow;
  logic          underflow;
  logic          clr_err;

  int vectors     = 0;
  int miscompares = 0;

  image_burst_fifo #(
    .WIDTH     (W),
    .ADDR_BITS (AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .M_Count    (M_Count),
    .S_Count    (S_Count),
    .dout       (dout),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .M_Valid    (M_Valid),
    .S_Ready    (S_Ready),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(data_count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_mvalid"}, 32'(M_Valid), 0);
    check({tag, "_sready"}, 32'(S_Ready), 1);
    check({tag, "_dout"},  32'(dout), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_udf"},   32'(underflow), 0);
  endtask

  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout;

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    clr_err = 1'b0;
    M_Count = 5'd4;
    S_Count = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // M_Valid threshold at 4 words
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    check("cnt3", 32'(data_count), 3);
    step(1'b0, 1'b0, 8'h00);
    check("mvalid_3", 32'(M_Valid), 0);
    step(1'b1, 1'b0, 8'h03);
    check("cnt4", 32'(data_count), 4);
    check("mvalid_lag", 32'(M_Valid), 0);
    step(1'b0, 1'b0, 8'h00);
    check("mvalid_4", 32'(M_Valid), 1);

    // Fill to full, then one dropped write
    for (int i = 4; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_cnt", 32'(data_count), 16);
    check("fill_full", 32'(full), 1);
    step(1'b1, 1'b0, 8'hAA);
    check("ovf_cnt", 32'(data_count), 16);
    check("ovf_full", 32'(full), 1);
    check("ovf_sready", 32'(S_Ready), 0);
    check("ovf_flag", 32'(overflow), ERR_EN);
    clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    check("ovf_clr", 32'(overflow), 0);

    // Drain in order, then an ignored read
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain_%0d", i), 32'(dout), i);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_cnt", 32'(data_count), 0);
    step(1'b0, 1'b1, 8'h00);
    check("udf_dout_hold", 32'(dout), 32'h0F);
    check("udf_flag", 32'(underflow), ERR_EN);
    clr_err = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    check("udf_set_wins", 32'(underflow), ERR_EN);
    step(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    check("udf_clr", 32'(underflow), 0);

    // S_Ready with S_Count=6 at 10 and 9 stored words
    S_Count = 5'd6;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(32 + i));
    step(1'b0, 1'b0, 8'h00);
    check("sr_cnt10", 32'(data_count), 10);
    check("sr_10", 32'(S_Ready), 0);
    step(1'b0, 1'b1, 8'h00);
    check("sr_rd_dout", 32'(dout), 32'h20);
    check("sr_cnt9", 32'(data_count), 9);
    step(1'b0, 1'b0, 8'h00);
    check("sr_9", 32'(S_Ready), 1);

    // Simultaneous read/write when full, then when empty
    for (int i = 10; i < 17; i++) step(1'b1, 1'b0, 8'(32 + i));
    check("both_full_pre", 32'(full), 1);
    step(1'b1, 1'b1, 8'hEE);
    check("both_full_dout", 32'(dout), 32'h21);
    check("both_full_cnt", 32'(data_count), 15);
    check("both_full_flag", 32'(full), 0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("drain2_%0d", i), 32'(dout), 32'h22 + i);
    end
    check("drain2_cnt", 32'(data_count), 0);
    step(1'b1, 1'b1, 8'h55);
    check("both_empty_cnt", 32'(data_count), 1);
    check("both_empty_dout", 32'(dout), 32'h30);
    check("both_empty_flag", 32'(empty), 0);
    step(1'b0, 1'b1, 8'h00);
    check("both_empty_rd", 32'(dout), 32'h55);
    check("both_empty_cnt0", 32'(data_count), 0);

    // Wrapping stream with a reset pulse at word 25
    S_Count  = 5'd0;
    M_Count  = 5'd4;
    exp_dout = 8'h55;
    q.delete();
    for (int k = 0; k < 40; k++) begin
      int   pre;
      logic r;
      pre = q.size();
      r   = (k % 2) == 1;
      rst = (k == 25);
      step(1'b1, r, 8'(128 + k));
      if (k == 25) begin
        rst = 1'b0;
        q.delete();
        exp_dout = '0;
        check_reset_state("strm_rst");
      end else begin
        if (r && pre > 0) exp_dout = q.pop_front();
        if (pre < D) q.push_back(8'(128 + k));
        check($sformatf("strm_dout_%0d", k), 32'(dout), 32'(exp_dout));
        check($sformatf("strm_cnt_%0d", k), 32'(data_count), q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
